// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : LSU operation/state types and operation decode helpers.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LW   = 4'd3,
    LSU_LD   = 4'd4,
    LSU_LBU  = 4'd5,
    LSU_LHU  = 4'd6,
    LSU_LWU  = 4'd7,
    LSU_SB   = 4'd8,
    LSU_SH   = 4'd9,
    LSU_SW   = 4'd10,
    LSU_SD   = 4'd11
  } lsu_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } lsu_state_t;

  function automatic logic lsu_is_load(input lsu_op_t op);
    return (op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU});
  endfunction

  function automatic logic lsu_is_store(input lsu_op_t op);
    return (op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SD});
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] lsu_size(input lsu_op_t op);
    logic [1:0] sz;
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: sz = 2'd0;
      LSU_LH, LSU_LHU, LSU_SH: sz = 2'd1;
      LSU_LW, LSU_LWU, LSU_SW: sz = 2'd2;
      default:                 sz = 2'd3;
    endcase
    return sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : byte enables, store-lane replication and load extraction.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  lsu_op_t          op_i,
  input  logic [2:0]       offset_i,
  input  logic [XLEN-1:0]  store_data_i,
  input  logic [63:0]      rdata_i,
  output logic [7:0]       be_o,
  output logic [63:0]      wdata_o,
  output logic [XLEN-1:0]  load_data_o,
  output logic             misaligned_o
);

  logic [1:0]  w_size;
  logic [2:0]  w_off;
  logic [63:0] w_shifted;
  logic        w_sext;

  always_comb begin
    w_size = lsu_size(op_i);
    w_sext = (op_i inside {LSU_LB, LSU_LH, LSU_LW});

    // Offset bits below the access size are dropped (align down)
    case (w_size)
      2'd0:    w_off = offset_i;
      2'd1:    w_off = {offset_i[2:1], 1'b0};
      2'd2:    w_off = {offset_i[2], 2'b00};
      default: w_off = 3'b000;
    endcase
    misaligned_o = (w_off != offset_i);

    case (w_size)
      2'd0:    be_o = 8'h01 << w_off;
      2'd1:    be_o = 8'h03 << w_off;
      2'd2:    be_o = 8'h0F << w_off;
      default: be_o = 8'hFF;
    endcase

    case (w_size)
      2'd0:    wdata_o = {8{store_data_i[7:0]}};
      2'd1:    wdata_o = {4{store_data_i[15:0]}};
      2'd2:    wdata_o = {2{store_data_i[31:0]}};
      default: wdata_o = store_data_i[63:0];
    endcase

    w_shifted = rdata_i >> {w_off, 3'b000};
    case (w_size)
      2'd0:    load_data_o = {{56{w_sext & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    load_data_o = {{48{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    load_data_o = {{32{w_sext & w_shifted[31]}}, w_shifted[31:0]};
      default: load_data_o = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit, one dmem transaction per access.
// Option LSU_MISALIGN_TRAP_EN: misaligned accesses fault without a request.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  lsu_op_t           lsu_op_i,
  output logic              stall_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              load_valid_o,
  output logic              fault_o,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [63:0]       dmem_wdata_o,
  output logic [7:0]        dmem_be_o,
  input  logic              dmem_rsp_valid_i,
  input  logic              dmem_rsp_err_i,
  input  logic [63:0]       dmem_rdata_i
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic MISALIGN_TRAP = 1'b1;
`else
  localparam logic MISALIGN_TRAP = 1'b0;
`endif

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        be_q;
  logic [XLEN-1:0]   data_q;
  logic              err_q;

  lsu_op_t           al_op;
  logic [2:0]        al_off;
  logic [7:0]        al_be;
  logic [63:0]       al_wdata;
  logic [XLEN-1:0]   al_load;
  logic              al_misaligned;
  logic              trap;
  logic              accept;

  // IDLE aligns the incoming request; afterwards the latched access drives extraction
  assign al_op  = (state_q == IDLE) ? lsu_op_i    : op_q;
  assign al_off = (state_q == IDLE) ? addr_i[2:0] : addr_q[2:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .op_i         (al_op),
    .offset_i     (al_off),
    .store_data_i (store_data_i),
    .rdata_i      (dmem_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_misaligned)
  );

  assign trap   = MISALIGN_TRAP & al_misaligned;
  assign accept = (state_q == IDLE) && (lsu_op_i != LSU_NONE) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = trap ? DONE : REQ;
      // A handshake coinciding with a flush still owes us a response
      REQ:   if (dmem_req_ready_i) state_d = flush_i ? DRAIN : WAIT;
             else if (flush_i)     state_d = IDLE;
      WAIT:  if (flush_i)               state_d = dmem_rsp_valid_i ? IDLE : DRAIN;
             else if (dmem_rsp_valid_i) state_d = DONE;
      DONE:  state_d = IDLE;
      DRAIN: if (dmem_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= LSU_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= lsu_op_i;
        addr_q  <= addr_i;
        wdata_q <= al_wdata;
        be_q    <= al_be;
        data_q  <= '0;
        err_q   <= trap;
      end
      if ((state_q == WAIT) && (state_d == DONE)) begin
        data_q <= al_load;
        err_q  <= dmem_rsp_err_i;
      end
    end
  end

  always_comb begin
    dmem_req_valid_o = (state_q == REQ);
    stall_o          = ((lsu_op_i != LSU_NONE) && (state_q != DONE)) || (state_q == DRAIN);
    load_valid_o     = (state_q == DONE) && lsu_is_load(op_q) && !err_q;
    fault_o          = (state_q == DONE) && err_q;
    load_data_o      = load_valid_o ? data_q : '0;
  end

  assign dmem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_we_o    = lsu_is_store(op_q);
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

`ifndef SYNTHESIS
  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == REQ) && dmem_rsp_valid_i));
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (dmem_req_valid_o && !dmem_req_ready_i && !flush_i) |=> dmem_req_valid_o);
`endif

endmodule

`default_nettype wire
